mips_multicycle_control: RTL and testbench

- Control FSM for the team's multicycle MIPS core, the successor to the single-cycle datapath.
- One memory port is shared by instruction fetch and data access, and the single ALU also computes PC+4 and the branch target.
- The block sequences all datapath enables per instruction class and stalls on a memory-ready handshake.
- Adds jumps (j, jal, jr), bne, lui and variable-latency memory.

---
 rtl/mips_pkg.sv | 97 +++++++++
 rtl/mips_multicycle_control_if.sv | 40 ++++
 rtl/mips_opcode_class.sv | 28 ++
 rtl/mips_multicycle_control.sv | 170 +++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, states, ALU op codes,
// datapath mux selects and the decoded instruction class.
package mips_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned STATE_W = 4;

  localparam logic [OP_W-1:0] OpRtype = 6'b000000;
  localparam logic [OP_W-1:0] OpJ     = 6'b000010;
  localparam logic [OP_W-1:0] OpJal   = 6'b000011;
  localparam logic [OP_W-1:0] OpBeq   = 6'b000100;
  localparam logic [OP_W-1:0] OpBne   = 6'b000101;
  localparam logic [OP_W-1:0] OpAddi  = 6'b001000;
  localparam logic [OP_W-1:0] OpAndi  = 6'b001100;
  localparam logic [OP_W-1:0] OpOri   = 6'b001101;
  localparam logic [OP_W-1:0] OpLui   = 6'b001111;
  localparam logic [OP_W-1:0] OpLw    = 6'b100011;
  localparam logic [OP_W-1:0] OpSw    = 6'b101011;

  localparam logic [FUNCT_W-1:0] FnJr = 6'b001000;

  typedef enum logic [STATE_W-1:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRExec   = 4'd6,
    StAluWb   = 4'd7,
    StBranch  = 4'd8,
    StIExec   = 4'd9,
    StJump    = 4'd10,
    StJal     = 4'd11,
    StJr      = 4'd12
  } state_e;

  localparam logic [ALUOP_W-1:0] AluAdd   = 3'b000;
  localparam logic [ALUOP_W-1:0] AluSub   = 3'b001;
  localparam logic [ALUOP_W-1:0] AluRtype = 3'b010;
  localparam logic [ALUOP_W-1:0] AluAnd   = 3'b011;
  localparam logic [ALUOP_W-1:0] AluOr    = 3'b100;
  localparam logic [ALUOP_W-1:0] AluLui   = 3'b101;

  localparam logic [1:0] RegDstRt    = 2'b00;
  localparam logic [1:0] RegDstRd    = 2'b01;
  localparam logic [1:0] RegDstRa    = 2'b10;
  localparam logic [1:0] MemToRegAlu = 2'b00;
  localparam logic [1:0] MemToRegMdr = 2'b01;
  localparam logic [1:0] MemToRegPc  = 2'b10;
  localparam logic [1:0] AluBReg     = 2'b00;
  localparam logic [1:0] AluBFour    = 2'b01;
  localparam logic [1:0] AluBImm     = 2'b10;
  localparam logic [1:0] AluBImmSh   = 2'b11;
  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;
  localparam logic [1:0] PcSrcReg    = 2'b11;

  // One-hot instruction class; all zero means illegal.
  typedef struct packed {
    logic rtype;
    logic jr;
    logic lw;
    logic sw;
    logic beq;
    logic bne;
    logic addi;
    logic andi;
    logic ori;
    logic lui;
    logic j;
    logic jal;
  } instr_class_t;

  typedef struct packed {
    logic               pc_write;
    logic               pc_write_beq;
    logic               pc_write_bne;
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic [1:0]         reg_dst;
    logic [1:0]         mem_to_reg;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic [1:0]         pc_source;
    logic               instr_done;
    logic               illegal_op;
  } ctrl_t;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control-to-datapath bundle: instruction fields and memory handshake in, enables out.
interface mips_multicycle_control_if;
  import mips_pkg::*;

  logic [OP_W-1:0]    opcode;
  logic [FUNCT_W-1:0] funct;
  logic               mem_ready;
  logic               pc_write;
  logic               pc_write_beq;
  logic               pc_write_bne;
  logic               iord;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic [1:0]         reg_dst;
  logic [1:0]         mem_to_reg;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [ALUOP_W-1:0] alu_op;
  logic [1:0]         pc_source;
  logic               instr_done;
  logic               illegal_op;
  logic [STATE_W-1:0] state_o;

  modport master (
    input  opcode, funct, mem_ready,
    output pc_write, pc_write_beq, pc_write_bne, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
           instr_done, illegal_op, state_o
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  pc_write, pc_write_beq, pc_write_bne, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
           instr_done, illegal_op, state_o
  );

endinterface

// File: rtl/mips_opcode_class.sv
// Combinational {opcode, funct} to one-hot instruction class; reusable by the pipelined decoder.
module mips_opcode_class
  import mips_pkg::*;
(
  input  logic [OP_W-1:0]    opcode_i,
  input  logic [FUNCT_W-1:0] funct_i,
  output instr_class_t       cls_o,
  output logic               illegal_o
);

  always_comb begin
    cls_o       = '0;
    cls_o.rtype = (opcode_i == OpRtype) && (funct_i != FnJr);
    cls_o.jr    = (opcode_i == OpRtype) && (funct_i == FnJr);
    cls_o.lw    = (opcode_i == OpLw);
    cls_o.sw    = (opcode_i == OpSw);
    cls_o.beq   = (opcode_i == OpBeq);
    cls_o.bne   = (opcode_i == OpBne);
    cls_o.addi  = (opcode_i == OpAddi);
    cls_o.andi  = (opcode_i == OpAndi);
    cls_o.ori   = (opcode_i == OpOri);
    cls_o.lui   = (opcode_i == OpLui);
    cls_o.j     = (opcode_i == OpJ);
    cls_o.jal   = (opcode_i == OpJal);
    illegal_o   = ~|cls_o;
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences datapath enables per instruction class and stalls
// on mem_ready in FETCH, MEM_RD and MEM_WR.
module mips_multicycle_control
  import mips_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  mips_multicycle_control_if.master ctrl
);

  state_e       state_q, state_d;
  logic [1:0]   reg_dst_q, reg_dst_d;
  instr_class_t cls;
  logic         illegal;
  ctrl_t        out;

  mips_opcode_class u_class (
    .opcode_i  (ctrl.opcode),
    .funct_i   (ctrl.funct),
    .cls_o     (cls),
    .illegal_o (illegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StFetch;
      reg_dst_q <= RegDstRt;
    end else begin
      state_q   <= state_d;
      reg_dst_q <= reg_dst_d;
    end
  end

  always_comb begin
    out       = '0;
    state_d   = state_q;
    reg_dst_d = reg_dst_q;
    unique case (state_q)
      StFetch: begin
        out.mem_read  = 1'b1;
        out.alu_src_b = AluBFour;
        out.alu_op    = AluAdd;
        if (ctrl.mem_ready) begin
          out.ir_write = 1'b1;
          out.pc_write = 1'b1;
          state_d      = StDecode;
        end
      end
      StDecode: begin
        // Speculative branch target lands in ALUOut for BRANCH.
        out.alu_src_b = AluBImmSh;
        out.alu_op    = AluAdd;
        if (cls.jr)                                     state_d = StJr;
        else if (cls.rtype)                             state_d = StRExec;
        else if (cls.lw || cls.sw)                      state_d = StMemAddr;
        else if (cls.beq || cls.bne)                    state_d = StBranch;
        else if (cls.addi || cls.andi || cls.ori || cls.lui) state_d = StIExec;
        else if (cls.j)                                 state_d = StJump;
        else if (cls.jal)                               state_d = StJal;
        else begin
          out.illegal_op = illegal;
          state_d        = StFetch;
        end
      end
      StMemAddr: begin
        out.alu_src_a = 1'b1;
        out.alu_src_b = AluBImm;
        out.alu_op    = AluAdd;
        state_d       = cls.sw ? StMemWr : StMemRd;
      end
      StMemRd: begin
        out.iord     = 1'b1;
        out.mem_read = 1'b1;
        if (ctrl.mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        out.reg_write  = 1'b1;
        out.reg_dst    = RegDstRt;
        out.mem_to_reg = MemToRegMdr;
        out.instr_done = 1'b1;
        state_d        = StFetch;
      end
      StMemWr: begin
        out.iord      = 1'b1;
        out.mem_write = 1'b1;
        if (ctrl.mem_ready) begin
          out.instr_done = 1'b1;
          state_d        = StFetch;
        end
      end
      StRExec: begin
        out.alu_src_a = 1'b1;
        out.alu_src_b = AluBReg;
        out.alu_op    = AluRtype;
        reg_dst_d     = RegDstRd;
        state_d       = StAluWb;
      end
      StIExec: begin
        out.alu_src_a = 1'b1;
        out.alu_src_b = AluBImm;
        if (cls.andi)     out.alu_op = AluAnd;
        else if (cls.ori) out.alu_op = AluOr;
        else if (cls.lui) out.alu_op = AluLui;
        else              out.alu_op = AluAdd;
        reg_dst_d = RegDstRt;
        state_d   = StAluWb;
      end
      StAluWb: begin
        out.reg_write  = 1'b1;
        out.reg_dst    = reg_dst_q;
        out.mem_to_reg = MemToRegAlu;
        out.instr_done = 1'b1;
        state_d        = StFetch;
      end
      StBranch: begin
        out.alu_src_a    = 1'b1;
        out.alu_src_b    = AluBReg;
        out.alu_op       = AluSub;
        out.pc_source    = PcSrcAluOut;
        out.pc_write_beq = cls.beq;
        out.pc_write_bne = cls.bne;
        out.instr_done   = 1'b1;
        state_d          = StFetch;
      end
      StJump: begin
        out.pc_source  = PcSrcJump;
        out.pc_write   = 1'b1;
        out.instr_done = 1'b1;
        state_d        = StFetch;
      end
      StJal: begin
        out.pc_source  = PcSrcJump;
        out.pc_write   = 1'b1;
        out.reg_write  = 1'b1;
        out.reg_dst    = RegDstRa;
        out.mem_to_reg = MemToRegPc;
        out.instr_done = 1'b1;
        state_d        = StFetch;
      end
      StJr: begin
        out.pc_source  = PcSrcReg;
        out.pc_write   = 1'b1;
        out.instr_done = 1'b1;
        state_d        = StFetch;
      end
      default: state_d = StFetch;
    endcase
    // Outputs are forced low for the whole reset window, not just after the next edge.
    if (reset) out = '0;
  end

  assign ctrl.pc_write     = out.pc_write;
  assign ctrl.pc_write_beq = out.pc_write_beq;
  assign ctrl.pc_write_bne = out.pc_write_bne;
  assign ctrl.iord         = out.iord;
  assign ctrl.mem_read     = out.mem_read;
  assign ctrl.mem_write    = out.mem_write;
  assign ctrl.ir_write     = out.ir_write;
  assign ctrl.reg_dst      = out.reg_dst;
  assign ctrl.mem_to_reg   = out.mem_to_reg;
  assign ctrl.reg_write    = out.reg_write;
  assign ctrl.alu_src_a    = out.alu_src_a;
  assign ctrl.alu_src_b    = out.alu_src_b;
  assign ctrl.alu_op       = out.alu_op;
  assign ctrl.pc_source    = out.pc_source;
  assign ctrl.instr_done   = out.instr_done;
  assign ctrl.illegal_op   = out.illegal_op;
  assign ctrl.state_o      = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench: each instruction is expanded from its class into the expected per-cycle
// control vectors, with random memory wait states, and compared cycle by cycle.
module tb_mips_multicycle_control;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_beq;
    logic       pc_write_bne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
    logic [3:0] state;
  } vec_t;

  typedef enum int {KR, KJr, KLw, KSw, KBr, KImm, KJ, KJal, KIll} kind_e;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t obs;

  mips_multicycle_control_if bus ();

  mips_multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    obs = '{bus.pc_write, bus.pc_write_beq, bus.pc_write_bne, bus.iord, bus.mem_read,
            bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write,
            bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_source, bus.instr_done,
            bus.illegal_op, bus.state_o};
  end

  task automatic check_vec(input string tag, input vec_t got, input vec_t want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h (op %b funct %b)", tag, got, want, bus.opcode,
               bus.funct);
    end
  endtask

  // Called at a falling edge: drive mem_ready, check, then advance to the next falling edge.
  task automatic cyc(input string tag, input vec_t want, input logic rdy);
    bus.mem_ready = rdy;
    #1;
    check_vec(tag, obs, want);
    @(negedge clk);
  endtask

  function automatic kind_e classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: return (fn == 6'b001000) ? KJr : KR;
      6'b100011: return KLw;
      6'b101011: return KSw;
      6'b000100, 6'b000101: return KBr;
      6'b001000, 6'b001100, 6'b001101, 6'b001111: return KImm;
      6'b000010: return KJ;
      6'b000011: return KJal;
      default: return KIll;
    endcase
  endfunction

  function automatic vec_t fetch_vec(input logic rdy);
    vec_t e = '0;
    e.mem_read  = 1'b1;
    e.alu_src_b = 2'b01;
    e.ir_write  = rdy;
    e.pc_write  = rdy;
    return e;
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int wf,
                           input int wm);
    vec_t  e;
    kind_e k = classify(op, fn);
    repeat (wf) cyc("fetch_wait", fetch_vec(1'b0), 1'b0);
    cyc("fetch", fetch_vec(1'b1), 1'b1);
    bus.opcode = op;
    bus.funct  = fn;
    e = '0;
    e.state      = 4'd1;
    e.alu_src_b  = 2'b11;
    e.illegal_op = (k == KIll);
    cyc("decode", e, rnd_bit());
    if (k == KIll) return;
    e = '0;
    case (k)
      KLw, KSw: begin
        e.state = 4'd2; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        cyc("mem_addr", e, rnd_bit());
        e = '0;
        e.iord = 1'b1;
        if (k == KLw) begin
          e.state = 4'd3; e.mem_read = 1'b1;
          repeat (wm) cyc("mem_rd_wait", e, 1'b0);
          cyc("mem_rd", e, 1'b1);
          e = '0;
          e.state = 4'd4; e.reg_write = 1'b1; e.mem_to_reg = 2'b01; e.instr_done = 1'b1;
          cyc("mem_wb", e, rnd_bit());
        end else begin
          e.state = 4'd5; e.mem_write = 1'b1;
          repeat (wm) cyc("mem_wr_wait", e, 1'b0);
          e.instr_done = 1'b1;
          cyc("mem_wr", e, 1'b1);
        end
      end
      KR, KImm: begin
        e.alu_src_a = 1'b1;
        if (k == KR) begin
          e.state = 4'd6; e.alu_op = 3'b010;
        end else begin
          e.state = 4'd9; e.alu_src_b = 2'b10;
          e.alu_op = (op == 6'b001100) ? 3'b011 : (op == 6'b001101) ? 3'b100 :
                     (op == 6'b001111) ? 3'b101 : 3'b000;
        end
        cyc("exec", e, rnd_bit());
        e = '0;
        e.state = 4'd7; e.reg_write = 1'b1; e.instr_done = 1'b1;
        e.reg_dst = (k == KR) ? 2'b01 : 2'b00;
        cyc("alu_wb", e, rnd_bit());
      end
      KBr: begin
        e.state = 4'd8; e.alu_src_a = 1'b1; e.alu_op = 3'b001; e.pc_source = 2'b01;
        e.pc_write_beq = (op == 6'b000100);
        e.pc_write_bne = (op == 6'b000101);
        e.instr_done   = 1'b1;
        cyc("branch", e, rnd_bit());
      end
      default: begin
        e.pc_write = 1'b1; e.instr_done = 1'b1;
        if (k == KJr) begin
          e.state = 4'd12; e.pc_source = 2'b11;
        end else begin
          e.pc_source = 2'b10;
          e.state     = (k == KJ) ? 4'd10 : 4'd11;
          if (k == KJal) begin
            e.reg_write = 1'b1; e.reg_dst = 2'b10; e.mem_to_reg = 2'b10;
          end
        end
        cyc("jump", e, rnd_bit());
      end
    endcase
  endtask

  logic [5:0] legal_ops [11];
  initial legal_ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h0c, 6'h0d, 6'h0f,
                        6'h02, 6'h03};

  initial begin
    vec_t e;
    logic [5:0] op, fn;
    bus.opcode    = '0;
    bus.funct     = '0;
    bus.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_vec("reset_outputs", obs, '0);
    @(negedge clk);
    reset = 1'b0;
    cyc("reset_release", fetch_vec(1'b0), 1'b0);

    // Abort a load in MEM_RD with an asynchronous reset.
    cyc("fetch", fetch_vec(1'b1), 1'b1);
    bus.opcode = 6'b100011;
    e = '0; e.state = 4'd1; e.alu_src_b = 2'b11;
    cyc("decode", e, 1'b0);
    e = '0; e.state = 4'd2; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
    cyc("mem_addr", e, 1'b1);
    e = '0; e.state = 4'd3; e.iord = 1'b1; e.mem_read = 1'b1;
    cyc("mem_rd_wait", e, 1'b0);
    #2 reset = 1'b1;
    #1 check_vec("reset_async", obs, '0);
    @(negedge clk);
    bus.mem_ready = 1'b1;
    #1 check_vec("reset_hold", obs, '0);
    reset = 1'b0;
    cyc("reset_release2", fetch_vec(1'b0), 1'b0);

    // Directed cases.
    run_instr(6'b000000, 6'b100000, 0, 0);  // add
    run_instr(6'b100011, 6'b000000, 0, 3);  // lw, 3 wait cycles
    run_instr(6'b101011, 6'b000000, 2, 1);  // sw with fetch wait
    run_instr(6'b000101, 6'b000000, 0, 0);  // bne
    run_instr(6'b000100, 6'b000000, 1, 0);  // beq
    run_instr(6'b000011, 6'b000000, 0, 0);  // jal
    run_instr(6'b111111, 6'b000000, 0, 0);  // illegal
    run_instr(6'b000000, 6'b001000, 0, 0);  // jr
    run_instr(6'b001111, 6'b000000, 0, 0);  // lui
    run_instr(6'b000010, 6'b000000, 0, 0);  // j

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      else op = legal_ops[$urandom_range(0, 10)];
      fn = ($urandom_range(0, 3) == 0) ? 6'b001000 : 6'($urandom);
      run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
